// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the serial adder sequencer tile.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Status byte bit positions; bits [7:6] read as zero.
  localparam int unsigned StatBusy    = 0;
  localparam int unsigned StatDone    = 1;
  localparam int unsigned StatCout    = 2;
  localparam int unsigned StatOvf     = 3;
  localparam int unsigned StatZero    = 4;
  localparam int unsigned StatLastSum = 5;

  // io_in pin assignments.
  localparam int unsigned PinClk     = 0;
  localparam int unsigned PinRst     = 1;
  localparam int unsigned PinStart   = 2;
  localparam int unsigned PinA       = 3;
  localparam int unsigned PinB       = 4;
  localparam int unsigned PinSub     = 5;
  localparam int unsigned PinHold    = 6;
  localparam int unsigned PinDispSel = 7;

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit combinational full adder used as the serial datapath.
module full_adder_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_adder_sequencer.sv
// Bit-serial add/subtract sequencer in an 8-in/8-out tile wrapper.
// Operands stream LSB-first; io_out is a registered result/status mux.
// Optional feature macro: SERIAL_ADDER_SUB_EN enables subtract via io_in[5].
module serial_adder_sequencer
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam logic [2:0] CntMax = 3'(WIDTH - 1);

  logic w_clk, w_rst, w_start, w_a, w_b, w_hold, w_disp_sel, w_sub_in;

  assign w_clk      = io_in[PinClk];
  assign w_rst      = io_in[PinRst];
  assign w_start    = io_in[PinStart];
  assign w_a        = io_in[PinA];
  assign w_b        = io_in[PinB];
  assign w_hold     = io_in[PinHold];
  assign w_disp_sel = io_in[PinDispSel];

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub_in = io_in[PinSub];
`else
  // Add-only build: the sub pin is masked off so the mode is always add.
  assign w_sub_in = io_in[PinSub] & 1'b0;
`endif

  state_e           r_state, w_state_next;
  logic             r_carry, r_sub_mode, r_zero, r_cout, r_ovf, r_last_sum;
  logic [2:0]       r_cnt;
  logic [WIDTH-1:0] r_result;
  logic [7:0]       r_out;

  logic w_load, w_accept, w_last;
  logic w_b_eff, w_sum, w_fa_cout;
  logic [7:0] w_status, w_result_ext;

  assign w_b_eff = w_b ^ r_sub_mode;

  full_adder_bit u_fa (
    .i_a    (w_a),
    .i_b    (w_b_eff),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_fa_cout)
  );

  // State register.
  always_ff @(posedge w_clk) begin
    if (w_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Next-state and datapath control strobes.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (w_start) begin
          w_state_next = StRun;
          w_load       = 1'b1;
        end
      end
      StRun: begin
        if (!w_hold) begin
          w_accept = 1'b1;
          if (r_cnt == CntMax) begin
            w_last       = 1'b1;
            w_state_next = StDone;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Carry, counter, result shift register and flags.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_carry    <= 1'b0;
      r_sub_mode <= 1'b0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_last_sum <= 1'b0;
    end else if (w_load) begin
      // Subtract is A + ~B + 1: the +1 enters as the initial carry.
      r_carry    <= w_sub_in;
      r_sub_mode <= w_sub_in;
      r_cnt      <= '0;
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_last_sum <= 1'b0;
    end else if (w_accept) begin
      r_carry    <= w_fa_cout;
      r_result   <= {w_sum, r_result[WIDTH-1:1]};
      r_zero     <= r_zero & ~w_sum;
      r_cnt      <= r_cnt + 3'd1;
      r_last_sum <= w_sum;
      if (w_last) begin
        r_cout <= w_fa_cout;
        // Signed overflow: carry into the MSB differs from carry out of it.
        r_ovf  <= r_carry ^ w_fa_cout;
      end
    end
  end

  // Status and zero-extended result bytes.
  always_comb begin
    w_status              = '0;
    w_status[StatBusy]    = (r_state == StRun);
    w_status[StatDone]    = (r_state == StDone);
    w_status[StatCout]    = r_cout;
    w_status[StatOvf]     = r_ovf;
    w_status[StatZero]    = r_zero;
    w_status[StatLastSum] = r_last_sum;
    w_result_ext              = '0;
    w_result_ext[WIDTH-1:0]   = r_result;
  end

  // Registered display mux.
  always_ff @(posedge w_clk) begin
    if (w_rst) r_out <= 8'h00;
    else       r_out <= w_disp_sel ? w_status : w_result_ext;
  end

  assign io_out = r_out;

endmodule

// File: tb/tb_serial_adder_sequencer.sv
// Self-checking bench for serial_adder_sequencer: directed and random operations
// checked against an arithmetic reference model.
module tb_serial_adder_sequencer;

  localparam int unsigned W = 8;
`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SubEn = 1'b1;
`else
  localparam bit SubEn = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, a_bit = 1'b0, b_bit = 1'b0;
  logic sub = 1'b0, hold = 1'b0, disp_sel = 1'b0;
  logic [7:0] io_in, io_out;
  int tests = 0, fails = 0, edges = 0;

  assign io_in = {disp_sel, hold, sub, b_bit, a_bit, start, rst, clk};

  serial_adder_sequencer #(.WIDTH(W)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Reference: two's-complement add/subtract on whole words.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input bit s,
                       output logic [7:0] res, output bit co, output bit ov);
    logic [8:0] sum;
    logic [7:0] bb;
    bit eff;
    eff = s & SubEn;
    bb  = eff ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + 9'(eff);
    res = sum[7:0];
    co  = sum[8];
    ov  = (a[7] == bb[7]) && (res[7] != a[7]);
  endtask

  // One full operation; hold_n cycles of hold are inserted before bit hold_at.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input bit s, input int hold_at, input int hold_n, input bit poke);
    logic [7:0] res, st;
    bit co, ov;
    int guard;
    model(a, b, s, res, co, ov);
    st = {2'b00, res[7], (res == 8'h00), ov, co, 1'b1, 1'b0};
    disp_sel = 1'b1;
    start = 1'b1;
    sub = s;
    edges = 0;
    tick();
    start = 1'b0;
    sub = $urandom_range(0, 1);
    for (int i = 0; i < W; i++) begin
      if (i == hold_at) begin
        for (int h = 0; h < hold_n; h++) begin
          hold = 1'b1;
          start = poke;
          a_bit = $urandom_range(0, 1);
          b_bit = $urandom_range(0, 1);
          tick();
        end
      end
      hold = 1'b0;
      start = poke && (i == 2);
      a_bit = a[i];
      b_bit = b[i];
      tick();
      if (i == 0) check({tag, " busy"}, {7'd0, io_out[0]}, 8'h01);
    end
    start = 1'b0;
    guard = 0;
    while (io_out[1] !== 1'b1 && guard < 6) begin
      tick();
      guard++;
    end
    check({tag, " latency"}, 8'(edges), 8'(W + 2 + hold_n));
    check({tag, " status"}, io_out, st);
    disp_sel = 1'b0;
    tick();
    check({tag, " result"}, io_out, res);
  endtask

  initial begin
    logic [7:0] ra, rb;
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("reset result", io_out, 8'h00);
    disp_sel = 1'b1;
    tick();
    check("reset status", io_out, 8'h00);
    rst = 1'b0;
    tick();
    check("idle status", io_out, 8'h00);

    run_op("add5a27", 8'h5A, 8'h27, 1'b0, -1, 0, 1'b0);
    run_op("addff01", 8'hFF, 8'h01, 1'b0, -1, 0, 1'b0);
    run_op("sub1020", 8'h10, 8'h20, 1'b1, -1, 0, 1'b0);
    run_op("holdpoke", 8'h5A, 8'h27, 1'b0, 4, 3, 1'b1);

    // Abort mid-run with reset, including reset and start together.
    disp_sel = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_bit = 1'b1;
      b_bit = 1'b0;
      tick();
    end
    rst = 1'b1;
    tick();
    check("abort out", io_out, 8'h00);
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    tick();
    check("rst+start idle", io_out, 8'h00);
    disp_sel = 1'b0;
    tick();
    check("abort result", io_out, 8'h00);
    run_op("add0304", 8'h03, 8'h04, 1'b0, -1, 0, 1'b0);

    // Restart directly from DONE.
    run_op("rerun", 8'h01, 8'h01, 1'b0, -1, 0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op("rand", ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
             $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
